axis_addone_arbiter: RTL and testbench

- Round-robin AXI4-Stream packet arbiter that shares a single add-one datapath between NUM_SRC upstream stream masters.
- Sits between the requesting streams (VIP masters in simulation) and the AddOne slave port.
- Grants one source at a time and holds the grant for a whole packet, until an accepted beat with tlast.
- Forwards beats through a one-deep registered output stage and tags each beat with its source index on m_tid.

---
 rtl/axis_addone_arbiter.sv | 138 +++++++++++++
 tb/tb_axis_addone_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_addone_arbiter.sv
// rtl/axis_addone_arbiter.sv - round-robin AXI-Stream packet arbiter feeding one add-one datapath
module axis_addone_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 3
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_tdata,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0] s_tkeep,
    input  logic [NUM_SRC-1:0]              s_tlast,
    input  logic [NUM_SRC-1:0]              s_tvalid,
    output logic [NUM_SRC-1:0]              s_tready,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic [DATA_WIDTH/8-1:0]         m_tkeep,
    output logic                            m_tlast,
    output logic [ID_WIDTH-1:0]             m_tid,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic [NUM_SRC-1:0]              grant,
    output logic                            busy
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [NUM_SRC-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic [KEEP_W-1:0]      tkeep_q, tkeep_d;
    logic                   tlast_q, tlast_d;
    logic [ID_WIDTH-1:0]    tid_q, tid_d;
    logic                   tvalid_q, tvalid_d;

    logic [IDX_W-1:0]       pick;
    logic                   pick_vld;
    logic                   accept;
    int                     idx;

    // Cyclic scan starting just after the last source that completed a packet.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = (int'(last_q) + i) % NUM_SRC;
            if (!pick_vld && s_tvalid[idx]) begin
                pick     = IDX_W'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        last_d   = last_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tid_d    = tid_q;
        tvalid_d = tvalid_q;
        s_tready = '0;
        accept   = 1'b0;

        if (tvalid_q && m_tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = NUM_SRC'(1) << pick;
                    gidx_d  = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_tready[gidx_q] = !tvalid_q || m_tready;
                accept           = s_tvalid[gidx_q] && s_tready[gidx_q];
                if (accept) begin
                    tdata_d  = s_tdata[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
                    tkeep_d  = s_tkeep[int'(gidx_q)*KEEP_W +: KEEP_W];
                    tlast_d  = s_tlast[gidx_q];
                    tid_d    = ID_WIDTH'(gidx_q);
                    tvalid_d = 1'b1;
                    if (s_tlast[gidx_q]) begin
                        last_d  = gidx_q;
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            last_q   <= IDX_W'(NUM_SRC - 1);
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tid_q    <= '0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            last_q   <= last_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            tid_q    <= tid_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign m_tdata  = tdata_q;
    assign m_tkeep  = tkeep_q;
    assign m_tlast  = tlast_q;
    assign m_tid    = tid_q;
    assign m_tvalid = tvalid_q;
    assign grant    = grant_q;
    assign busy     = (state_q == BUSY);

endmodule

// File: tb/tb_axis_addone_arbiter.sv
// tb/tb_axis_addone_arbiter.sv - directed self-checking bench for axis_addone_arbiter
module tb_axis_addone_arbiter;

    localparam int NS = 2;
    localparam int DW = 32;
    localparam int IW = 3;
    localparam int KW = DW / 8;

    logic              aclk = 1'b0;
    logic              areset;
    logic [NS*DW-1:0]  s_tdata;
    logic [NS*KW-1:0]  s_tkeep;
    logic [NS-1:0]     s_tlast;
    logic [NS-1:0]     s_tvalid;
    logic [NS-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tlast;
    logic [IW-1:0]     m_tid;
    logic              m_tvalid;
    logic              m_tready;
    logic [NS-1:0]     grant;
    logic              busy;

    axis_addone_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .aclk(aclk), .areset(areset),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .grant(grant), .busy(busy)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [IW-1:0] tid;
        beat_t         beat;
        logic [31:0]   cyc;
    } obs_t;

    beat_t         q0[$];
    beat_t         q1[$];
    obs_t          out_q[$];
    logic [NS-1:0] grant_log[$];
    int            ready_pat[$];
    bit            rand_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int idle_rdy, nongrant_rdy, stall_rdy, hold_viol, timeouts;

    function automatic beat_t mk(logic [DW-1:0] d, logic [KW-1:0] k, logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        return b;
    endfunction

    function automatic logic [DW-1:0] addone(logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int j = 0; j < KW; j++) r[j*8 +: 8] = d[j*8 +: 8] + 8'd1;
        return r;
    endfunction

    task automatic clear_logs();
        out_q.delete();
        grant_log.delete();
        ready_pat.delete();
        rand_ready   = 1'b0;
        idle_rdy     = 0;
        nongrant_rdy = 0;
        stall_rdy    = 0;
        hold_viol    = 0;
        timeouts     = 0;
    endtask

    task automatic apply_reset();
        @(negedge aclk);
        areset   = 1'b1;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        q0.delete();
        q1.delete();
        clear_logs();
    endtask

    // Drives queued beats as AXI-Stream masters and records what the sink accepts.
    task automatic run_traffic(input int max_cyc, input int stop_acc);
        int           cyc  = 0;
        int           acc  = 0;
        bit           done = 0;
        bit           a0, a1, prev_stall;
        logic [DW+KW+IW:0] prev_out;
        obs_t         o;
        prev_stall = 1'b0;
        prev_out   = '0;
        while (!done) begin
            @(negedge aclk);
            if (rand_ready)               m_tready = 1'($urandom_range(0, 1));
            else if (ready_pat.size() > 0) m_tready = 1'(ready_pat[cyc % ready_pat.size()]);
            else                          m_tready = 1'b1;
            if (q0.size() > 0) begin
                s_tvalid[0] = 1'b1; s_tdata[DW-1:0] = q0[0].data;
                s_tkeep[KW-1:0] = q0[0].keep; s_tlast[0] = q0[0].last;
            end else s_tvalid[0] = 1'b0;
            if (q1.size() > 0) begin
                s_tvalid[1] = 1'b1; s_tdata[2*DW-1:DW] = q1[0].data;
                s_tkeep[2*KW-1:KW] = q1[0].keep; s_tlast[1] = q1[0].last;
            end else s_tvalid[1] = 1'b0;
            #2;
            grant_log.push_back(grant);
            if (!busy && s_tready != '0) idle_rdy++;
            if ((s_tready & ~grant) != '0) nongrant_rdy++;
            if (m_tvalid && !m_tready && s_tready != '0) stall_rdy++;
            if (prev_stall && (!m_tvalid || {m_tdata, m_tkeep, m_tlast, m_tid} !== prev_out)) hold_viol++;
            prev_stall = m_tvalid && !m_tready;
            prev_out   = {m_tdata, m_tkeep, m_tlast, m_tid};
            if (m_tvalid && m_tready) begin
                o.tid  = m_tid;
                o.beat = mk(m_tdata, m_tkeep, m_tlast);
                o.cyc  = 32'(cyc);
                out_q.push_back(o);
            end
            a0 = s_tvalid[0] && s_tready[0];
            a1 = s_tvalid[1] && s_tready[1];
            @(posedge aclk);
            if (a0) void'(q0.pop_front());
            if (a1) void'(q1.pop_front());
            acc += int'(a0) + int'(a1);
            cyc++;
            #1;
            if (q0.size() == 0) s_tvalid[0] = 1'b0;
            if (q1.size() == 0) s_tvalid[1] = 1'b0;
            if (stop_acc > 0 && acc >= stop_acc) done = 1;
            else if (stop_acc == 0 && q0.size() == 0 && q1.size() == 0 && !m_tvalid) done = 1;
            else if (cyc >= max_cyc) begin
                timeouts++;
                done = 1;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #2;
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid: got %b expected 0", m_tvalid); end
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", grant); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (s_tready !== 2'b00) begin n_fail++; $display("FAIL reset_s_tready: got %b expected 00", s_tready); end
        n_checks++;
        if ({m_tdata, m_tkeep, m_tlast, m_tid} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got data=%h keep=%h last=%b tid=%0d expected all 0", m_tdata, m_tkeep, m_tlast, m_tid);
        end
    endtask

    task automatic test_two_single();
        apply_reset();
        q0.push_back(mk(32'h03020100, 4'hF, 1'b1));
        q1.push_back(mk(32'h07060504, 4'hF, 1'b1));
        run_traffic(40, 0);
        n_checks++; if (timeouts !== 0) begin n_fail++; $display("FAIL two_single_timeout: got %0d expected 0", timeouts); end
        n_checks++; if (out_q.size() !== 2) begin n_fail++; $display("FAIL two_single_count: got %0d expected 2", out_q.size()); end
        if (out_q.size() == 2) begin
            n_checks++; if (out_q[0].tid !== 3'd0 || out_q[0].beat.data !== 32'h03020100) begin
                n_fail++; $display("FAIL two_single_first: got tid=%0d data=%h expected tid=0 data=03020100", out_q[0].tid, out_q[0].beat.data); end
            n_checks++; if (out_q[1].tid !== 3'd1 || out_q[1].beat.data !== 32'h07060504) begin
                n_fail++; $display("FAIL two_single_second: got tid=%0d data=%h expected tid=1 data=07060504", out_q[1].tid, out_q[1].beat.data); end
        end
        n_checks++; if (idle_rdy !== 0) begin n_fail++; $display("FAIL two_single_idle_ready: got %0d cycles expected 0", idle_rdy); end
    endtask

    task automatic test_four_beat();
        apply_reset();
        for (int i = 0; i < 4; i++) q0.push_back(mk(32'(i), 4'hF, 1'(i == 3)));
        run_traffic(40, 0);
        n_checks++; if (timeouts !== 0) begin n_fail++; $display("FAIL four_beat_timeout: got %0d expected 0", timeouts); end
        n_checks++; if (out_q.size() !== 4) begin n_fail++; $display("FAIL four_beat_count: got %0d expected 4", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 4; i++) begin
            n_checks++;
            if (out_q[i].beat.data !== 32'(i) || out_q[i].beat.last !== 1'(i == 3) || out_q[i].cyc !== 32'(2 + i) || out_q[i].tid !== 3'd0) begin
                n_fail++; $display("FAIL four_beat_beat%0d: got data=%h last=%b cyc=%0d tid=%0d expected data=%h last=%b cyc=%0d tid=0",
                                   i, out_q[i].beat.data, out_q[i].beat.last, out_q[i].cyc, out_q[i].tid, 32'(i), 1'(i == 3), 2 + i);
            end
        end
        n_checks++; if (grant_log.size() < 6) begin n_fail++; $display("FAIL four_beat_log: got %0d cycles expected >= 6", grant_log.size()); end
        if (grant_log.size() >= 6) begin
            for (int c = 0; c < 6; c++) begin
                n_checks++;
                if (grant_log[c] !== ((c >= 1 && c <= 4) ? 2'b01 : 2'b00)) begin
                    n_fail++; $display("FAIL four_beat_grant_c%0d: got %b expected %b", c, grant_log[c], (c >= 1 && c <= 4) ? 2'b01 : 2'b00);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_d[$];
        int            exp_t[$];
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 2; b++) begin
                q0.push_back(mk({8'hA0, 8'(p), 8'(b), 8'h00}, 4'hF, 1'(b == 1)));
                q1.push_back(mk({8'hB1, 8'(p), 8'(b), 8'h11}, 4'hF, 1'(b == 1)));
            end
        end
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 2; b++) begin exp_d.push_back({8'hA0, 8'(p), 8'(b), 8'h00}); exp_t.push_back(0); end
            for (int b = 0; b < 2; b++) begin exp_d.push_back({8'hB1, 8'(p), 8'(b), 8'h11}); exp_t.push_back(1); end
        end
        run_traffic(100, 0);
        n_checks++; if (timeouts !== 0) begin n_fail++; $display("FAIL b2b_timeout: got %0d expected 0", timeouts); end
        n_checks++; if (out_q.size() !== 12) begin n_fail++; $display("FAIL b2b_count: got %0d expected 12", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 12; i++) begin
            n_checks++;
            if (out_q[i].beat.data !== exp_d[i] || out_q[i].tid !== 3'(exp_t[i])) begin
                n_fail++; $display("FAIL b2b_beat%0d: got tid=%0d data=%h expected tid=%0d data=%h", i, out_q[i].tid, out_q[i].beat.data, exp_t[i], exp_d[i]);
            end
        end
        n_checks++; if (nongrant_rdy !== 0) begin n_fail++; $display("FAIL b2b_nongrant_ready: got %0d cycles expected 0", nongrant_rdy); end
    endtask

    task automatic test_stall();
        apply_reset();
        for (int i = 0; i < 4; i++) q1.push_back(mk(32'hC0DE_0000 + 32'(i), (i == 3) ? 4'h3 : 4'hF, 1'(i == 3)));
        ready_pat.push_back(1); ready_pat.push_back(0); ready_pat.push_back(0); ready_pat.push_back(1);
        run_traffic(60, 0);
        n_checks++; if (timeouts !== 0) begin n_fail++; $display("FAIL stall_timeout: got %0d expected 0", timeouts); end
        n_checks++; if (out_q.size() !== 4) begin n_fail++; $display("FAIL stall_count: got %0d expected 4", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 4; i++) begin
            n_checks++;
            if (out_q[i].beat.data !== 32'hC0DE_0000 + 32'(i) || out_q[i].tid !== 3'd1 || out_q[i].beat.keep !== ((i == 3) ? 4'h3 : 4'hF)) begin
                n_fail++; $display("FAIL stall_beat%0d: got tid=%0d data=%h keep=%h expected tid=1 data=%h keep=%h",
                                   i, out_q[i].tid, out_q[i].beat.data, out_q[i].beat.keep, 32'hC0DE_0000 + 32'(i), (i == 3) ? 4'h3 : 4'hF);
            end
        end
        n_checks++; if (stall_rdy !== 0) begin n_fail++; $display("FAIL stall_ready_low: got %0d cycles expected 0", stall_rdy); end
        n_checks++; if (hold_viol !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d changes expected 0", hold_viol); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        q0.push_back(mk(32'h1111_0000, 4'hF, 1'b1));
        run_traffic(20, 0);
        for (int i = 0; i < 5; i++) q0.push_back(mk(32'h2222_0000 + 32'(i), 4'hF, 1'(i == 4)));
        run_traffic(20, 2);
        n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid: got %b expected 1", m_tvalid); end
        areset   = 1'b1;
        s_tvalid = '0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_tvalid: got %b expected 0", m_tvalid); end
        n_checks++; if (grant !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_grant: got grant=%b busy=%b expected 00/0", grant, busy); end
        q0.delete();
        clear_logs();
        q0.push_back(mk(32'h3333_0000, 4'hF, 1'b1));
        q1.push_back(mk(32'h4444_0000, 4'hF, 1'b1));
        run_traffic(40, 0);
        n_checks++; if (out_q.size() !== 2) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 2", out_q.size()); end
        if (out_q.size() == 2) begin
            n_checks++; if (out_q[0].tid !== 3'd0 || out_q[0].beat.data !== 32'h3333_0000) begin
                n_fail++; $display("FAIL rstmid_first: got tid=%0d data=%h expected tid=0 data=33330000", out_q[0].tid, out_q[0].beat.data); end
        end
    endtask

    task automatic test_addone();
        logic [DW-1:0] src, exp;
        int            bad = 0;
        apply_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < KW; j++) src[j*8 +: 8] = 8'(i*4 + j);
            q1.push_back(mk(src, 4'hF, 1'(i == 255)));
        end
        run_traffic(3000, 0);
        n_checks++; if (timeouts !== 0) begin n_fail++; $display("FAIL addone_timeout: got %0d expected 0", timeouts); end
        n_checks++; if (out_q.size() !== 256) begin n_fail++; $display("FAIL addone_count: got %0d expected 256", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 256; i++) begin
            for (int j = 0; j < KW; j++) exp[j*8 +: 8] = 8'(i*4 + j + 1);
            if (addone(out_q[i].beat.data) !== exp || out_q[i].tid !== 3'd1) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL addone_sink: got %0d bad beats expected 0", bad); end
        n_checks++; if (hold_viol !== 0) begin n_fail++; $display("FAIL addone_hold: got %0d changes expected 0", hold_viol); end
    endtask

    initial begin
        areset   = 1'b1;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
        test_reset();
        test_two_single();
        test_four_beat();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_addone();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
